// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared types and constants for the alarm request arbiter
// Purpose: state enum, requester indices and requester count.
// Ports: none (package).
package alarm_pkg;

  localparam int NUM_REQ = 4;

  // Requester indices; a higher index means a higher priority.
  localparam int REQ_KEY    = 0;
  localparam int REQ_CHIME  = 1;
  localparam int REQ_SNOOZE = 2;
  localparam int REQ_ALARM  = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alarm_req_arbiter_if.sv
// rtl/alarm_req_arbiter_if.sv - request/grant bundle between event sources and arbiter
// Purpose: groups the request/done inputs and grant/status outputs of the arbiter.
// Signals: req[3:0], done (to arbiter); grant[3:0], grant_id[1:0], busy, timeout (from arbiter).
// Modports: slave = arbiter side, master = requester/driver side.
interface alarm_req_arbiter_if;
  import alarm_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic               done;
  logic [NUM_REQ-1:0] grant;
  logic [1:0]         grant_id;
  logic               busy;
  logic               timeout;

  modport slave (
    input  req,
    input  done,
    output grant,
    output grant_id,
    output busy,
    output timeout
  );

  modport master (
    output req,
    output done,
    input  grant,
    input  grant_id,
    input  busy,
    input  timeout
  );

endinterface

// File: rtl/req_prio_select.sv
// rtl/req_prio_select.sv - combinational highest-set-index select
// Purpose: picks the highest set bit of the request vector (index 3 wins).
// Ports: i_req[3:0] request vector; o_valid any bit set; o_idx[1:0] highest set index (0 when none).
module req_prio_select
  import alarm_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  output logic               o_valid,
  output logic [1:0]         o_idx
);

  always_comb begin
    o_valid = 1'b0;
    o_idx   = 2'd0;
    // Ascending scan: the last set bit seen is the highest one.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (i_req[i]) begin
        o_valid = 1'b1;
        o_idx   = 2'(i);
      end
    end
  end

endmodule

// File: rtl/alarm_req_arbiter.sv
// rtl/alarm_req_arbiter.sv - fixed-priority buzzer/display arbiter with hold, timeout, preempt and dead time
// Purpose: grants the shared buzzer to one of four requesters (3 = alarm highest),
//          holds it until done/withdraw/timeout/preempt, then inserts GAP_CYCLES of dead time.
// Ports: clk rising-edge clock; rst_n async active-low reset;
//        bus (slave): req[3:0], done in; grant[3:0], grant_id[1:0], busy, timeout out (all registered).
module alarm_req_arbiter
  import alarm_pkg::*;
#(
  parameter int MAX_HOLD   = 1024,
  parameter int GAP_CYCLES = 4,
  parameter int PREEMPT    = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  alarm_req_arbiter_if.slave bus
);

  localparam int HW = $clog2(MAX_HOLD);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  arb_state_e         r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [1:0]         r_grant_id;
  logic               r_busy;
  logic               r_timeout;
  logic [HW-1:0]      r_hold;
  logic [GW-1:0]      r_gap;

  logic       w_sel_valid;
  logic [1:0] w_sel_idx;
  logic       w_withdraw;
  logic       w_expired;
  logic       w_preempt;
  logic       w_release;

  // One selector serves both the IDLE choice and the preempt compare: the
  // highest pending index is above the owner exactly when a higher bit is set.
  req_prio_select u_sel (
    .i_req   (bus.req),
    .o_valid (w_sel_valid),
    .o_idx   (w_sel_idx)
  );

  assign w_withdraw = ~bus.req[r_grant_id];
  assign w_expired  = (r_hold == HOLD_LAST);
  assign w_preempt  = (PREEMPT != 0) && w_sel_valid && (w_sel_idx > r_grant_id);
  assign w_release  = bus.done | w_withdraw | w_expired | w_preempt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_grant_id <= '0;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
      r_hold     <= '0;
      r_gap      <= '0;
    end else begin
      r_timeout <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_sel_valid) begin
            r_state    <= ACTIVE;
            r_grant    <= ONE_HOT0 << w_sel_idx;
            r_grant_id <= w_sel_idx;
            r_busy     <= 1'b1;
            r_hold     <= '0;
          end else begin
            r_busy <= 1'b0;
          end
        end
        ACTIVE: begin
          if (w_release) begin
            r_grant    <= '0;
            r_grant_id <= '0;
            // Timeout only when the hold limit alone caused the release.
            r_timeout  <= w_expired & ~bus.done & ~w_withdraw & ~w_preempt;
            if (GAP_CYCLES > 0) begin
              r_state <= GAP;
              r_busy  <= 1'b1;
              r_gap   <= '0;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end
        GAP: begin
          if (r_gap == GAP_LAST) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant    = r_grant;
  assign bus.grant_id = r_grant_id;
  assign bus.busy     = r_busy;
  assign bus.timeout  = r_timeout;

endmodule

// File: tb/tb_alarm_req_arbiter.sv
// tb/tb_alarm_req_arbiter.sv - directed self-checking bench for alarm_req_arbiter
module tb_alarm_req_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  alarm_req_arbiter_if ia ();
  alarm_req_arbiter_if ib ();

  // A: gap of 4, no preemption. B: no gap, preemption enabled.
  alarm_req_arbiter #(.MAX_HOLD(8), .GAP_CYCLES(4), .PREEMPT(0)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ia.slave)
  );

  alarm_req_arbiter #(.MAX_HOLD(8), .GAP_CYCLES(0), .PREEMPT(1)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ib.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_a(input string tag, input logic [3:0] g, input logic [1:0] id,
                       input logic b, input logic t);
    chk({tag, ".grant"},    {4'd0, ia.grant},    {4'd0, g});
    chk({tag, ".grant_id"}, {6'd0, ia.grant_id}, {6'd0, id});
    chk({tag, ".busy"},     {7'd0, ia.busy},     {7'd0, b});
    chk({tag, ".timeout"},  {7'd0, ia.timeout},  {7'd0, t});
  endtask

  task automatic chk_b(input string tag, input logic [3:0] g, input logic [1:0] id,
                       input logic b, input logic t);
    chk({tag, ".grant"},    {4'd0, ib.grant},    {4'd0, g});
    chk({tag, ".grant_id"}, {6'd0, ib.grant_id}, {6'd0, id});
    chk({tag, ".busy"},     {7'd0, ib.busy},     {7'd0, b});
    chk({tag, ".timeout"},  {7'd0, ib.timeout},  {7'd0, t});
  endtask

  initial begin
    ia.req = '0; ia.done = 1'b0;
    ib.req = '0; ib.done = 1'b0;

    // Reset held for 3 cycles.
    repeat (3) tick();
    chk_a("rst_a", 4'b0000, 2'd0, 1'b0, 1'b0);
    chk_b("rst_b", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Basic grant, done, 4-cycle gap.
    ia.req = 4'b0010;
    tick();
    chk_a("basic_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
    ia.done = 1'b1;
    tick();
    chk_a("basic_rel", 4'b0000, 2'd0, 1'b1, 1'b0);
    ia.done = 1'b0; ia.req = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_a("basic_gap", 4'b0000, 2'd0, 1'b1, 1'b0);
    end
    tick();
    chk_a("basic_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Priority: 1011 -> alarm wins; then chime after gap.
    ia.req = 4'b1011;
    tick();
    chk_a("prio_grant3", 4'b1000, 2'd3, 1'b1, 1'b0);
    ia.done = 1'b1; ia.req = 4'b0011;
    tick();
    chk_a("prio_rel", 4'b0000, 2'd0, 1'b1, 1'b0);
    ia.done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_a("prio_gap", 4'b0000, 2'd0, 1'b1, 1'b0);
    end
    tick();
    chk_a("prio_gap_end", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    chk_a("prio_grant1", 4'b0010, 2'd1, 1'b1, 1'b0);
    ia.done = 1'b1; ia.req = 4'b0000;
    tick();
    ia.done = 1'b0;
    repeat (4) tick();
    chk_a("prio_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Timeout: req[0] held, no done -> 8 ACTIVE cycles then forced release.
    ia.req = 4'b0001;
    tick();
    chk_a("to_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk_a("to_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    tick();
    chk_a("to_rel", 4'b0000, 2'd0, 1'b1, 1'b1);
    tick();
    chk_a("to_pulse_end", 4'b0000, 2'd0, 1'b1, 1'b0);
    repeat (3) tick();
    chk_a("to_gap_end", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    chk_a("to_regrant", 4'b0001, 2'd0, 1'b1, 1'b0);
    repeat (7) tick();
    chk_a("to_cycle8", 4'b0001, 2'd0, 1'b1, 1'b0);
    ia.done = 1'b1;
    tick();
    chk_a("done_at_limit", 4'b0000, 2'd0, 1'b1, 1'b0);
    ia.done = 1'b0; ia.req = 4'b0000;
    tick();
    chk_a("done_at_limit_nopulse", 4'b0000, 2'd0, 1'b1, 1'b0);
    repeat (3) tick();
    chk_a("to2_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Preempt on B.
    ib.req = 4'b0010;
    tick();
    chk_b("pre_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
    ib.req = 4'b0110;
    tick();
    chk_b("pre_rel", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    chk_b("pre_regrant", 4'b0100, 2'd2, 1'b1, 1'b0);
    ib.req = 4'b0000;
    tick();
    chk_b("pre_withdraw", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Same stimulus on A: no preemption.
    ia.req = 4'b0010;
    tick();
    chk_a("nopre_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
    ia.req = 4'b0110;
    tick();
    chk_a("nopre_hold1", 4'b0010, 2'd1, 1'b1, 1'b0);
    tick();
    chk_a("nopre_hold2", 4'b0010, 2'd1, 1'b1, 1'b0);
    ia.done = 1'b1;
    tick();
    chk_a("nopre_rel", 4'b0000, 2'd0, 1'b1, 1'b0);
    ia.done = 1'b0; ia.req = 4'b0000;
    repeat (4) tick();
    chk_a("nopre_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Withdraw with zero gap on B: pending req[0] granted right after.
    ib.req = 4'b0011;
    tick();
    chk_b("wd_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
    tick();
    chk_b("wd_hold", 4'b0010, 2'd1, 1'b1, 1'b0);
    ib.req = 4'b0001;
    tick();
    chk_b("wd_rel", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    chk_b("wd_pending", 4'b0001, 2'd0, 1'b1, 1'b0);
    ib.req = 4'b0000;
    tick();
    chk_b("wd_rel0", 4'b0000, 2'd0, 1'b0, 1'b0);
    ib.done = 1'b1;
    tick();
    chk_b("idle_done1", 4'b0000, 2'd0, 1'b0, 1'b0);
    ib.done = 1'b0;
    tick();
    chk_b("idle_done2", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Async reset mid-grant on A.
    ia.req = 4'b1000;
    tick();
    chk_a("ar_grant", 4'b1000, 2'd3, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_a("ar_async", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    chk_a("ar_held", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_a("ar_regrant", 4'b1000, 2'd3, 1'b1, 1'b0);
    ia.req = 4'b0000;
    tick();
    chk_a("ar_rel", 4'b0000, 2'd0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
